// File: rtl/vmem_scanner.sv
// vmem_scanner: owns the VGA raster and, once per continuation token, scans one
// full frame of the cell colour RAM out to the DAC, then passes the token on.
module vmem_scanner #(
    parameter int                    MEM_BITS   = 11,
    parameter int                    COLOR_SIZE = 3,
    parameter int                    GRID_W     = 34,
    parameter int                    GRID_H     = 33,
    parameter int                    CELL_LOG2  = 3,
    parameter int                    X_OFF      = 184,
    parameter int                    Y_OFF      = 108,
    parameter logic [COLOR_SIZE-1:0] BG_COLOR   = '0,
    parameter int                    H_VIS      = 640,
    parameter int                    H_FP       = 16,
    parameter int                    H_SYNC     = 96,
    parameter int                    H_BP       = 48,
    parameter int                    V_VIS      = 480,
    parameter int                    V_FP       = 10,
    parameter int                    V_SYNC     = 2,
    parameter int                    V_BP       = 33
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic                  in_cont_signal,
    output logic                  out_cont_signal,
    input  logic                  next_fin_signal,
    output logic [MEM_BITS-1:0]   read_addr,
    input  logic [COLOR_SIZE-1:0] read_data,
    output logic                  VGA_CLK,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic                  VGA_BLANK_N,
    output logic                  VGA_SYNC_N,
    output logic [9:0]            VGA_R,
    output logic [9:0]            VGA_G,
    output logic [9:0]            VGA_B
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int CW    = $clog2(H_TOT > V_TOT ? H_TOT : V_TOT);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 1);
    localparam logic [CW-1:0] V_END  = CW'(V_VIS - 1);
    localparam logic [CW-1:0] H_VC   = CW'(H_VIS);
    localparam logic [CW-1:0] V_VC   = CW'(V_VIS);
    localparam logic [CW-1:0] HS_LO  = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] HS_HI  = CW'(H_VIS + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_LO  = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] VS_HI  = CW'(V_VIS + V_FP + V_SYNC);
    localparam logic [CW-1:0] X_LO   = CW'(X_OFF);
    localparam logic [CW-1:0] X_HI   = CW'(X_OFF + (GRID_W << CELL_LOG2));
    localparam logic [CW-1:0] Y_LO   = CW'(Y_OFF);
    localparam logic [CW-1:0] Y_HI   = CW'(Y_OFF + (GRID_H << CELL_LOG2));

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SCAN,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  tog;
    logic                  pix_en;
    logic [CW-1:0]         hcount;
    logic [CW-1:0]         vcount;
    logic [CW-1:0]         h_nxt;
    logic [CW-1:0]         v_nxt;
    logic [CW-1:0]         dx;
    logic [CW-1:0]         dy;
    logic [CW-1:0]         cx;
    logic [CW-1:0]         cy;
    logic [MEM_BITS-1:0]   cell_addr;
    logic                  in_win;
    logic                  wrap;
    logic                  vis_end;
    logic                  p_vis;
    logic                  p_hs;
    logic                  p_vs;
    logic                  p_win;
    logic                  p_scan;
    logic [COLOR_SIZE-1:0] pix_color;

    assign pix_en     = tog;
    assign VGA_CLK    = tog;
    assign VGA_SYNC_N = 1'b0;

    // Pixel tick: divide Clck by two; the toggle doubles as VGA_CLK.
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) tog <= 1'b0;
        else       tog <= ~tog;
    end

    // Next raster position, and the frame events the FSM keys on.
    always_comb begin
        h_nxt = hcount + 1'b1;
        v_nxt = vcount;
        if (hcount == H_LAST) begin
            h_nxt = '0;
            v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end
        wrap    = pix_en && hcount == H_LAST && vcount == V_LAST;
        vis_end = pix_en && hcount == H_LAST && vcount == V_END;
    end

    // Free-running raster counters, advancing once per pixel.
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            hcount <= h_nxt;
            vcount <= v_nxt;
        end
    end

    // Cell address of the upcoming pixel; row stride 34 built from shifts.
    always_comb begin
        in_win = (h_nxt >= X_LO) && (h_nxt < X_HI) &&
                 (v_nxt >= Y_LO) && (v_nxt < Y_HI);
        dx = h_nxt - X_LO;
        dy = v_nxt - Y_LO;
        cx = dx >> CELL_LOG2;
        cy = dy >> CELL_LOG2;
        cell_addr = (MEM_BITS'(cy) << 5) + (MEM_BITS'(cy) << 1) +
                    MEM_BITS'(cx);
    end

    // Token FSM: wait for a token, align to frame start, scan, hand off.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_cont_signal)  state_nxt = ARM;
            ARM:  if (wrap)            state_nxt = SCAN;
            SCAN: if (vis_end)         state_nxt = DONE;
            DONE: if (next_fin_signal) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // State register and the registered completion token.
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            out_cont_signal <= 1'b0;
        end else begin
            state           <= state_nxt;
            out_cont_signal <= (state_nxt == DONE);
        end
    end

    // Stage 1: issue the RAM address and capture this pixel's attributes.
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            read_addr <= '0;
            p_vis     <= 1'b0;
            p_hs      <= 1'b1;
            p_vs      <= 1'b1;
            p_win     <= 1'b0;
            p_scan    <= 1'b0;
        end else if (pix_en) begin
            read_addr <= (state_nxt == SCAN && in_win) ? cell_addr : '0;
            p_vis     <= (h_nxt < H_VC) && (v_nxt < V_VC);
            p_hs      <= !((h_nxt >= HS_LO) && (h_nxt < HS_HI));
            p_vs      <= !((v_nxt >= VS_LO) && (v_nxt < VS_HI));
            p_win     <= in_win;
            p_scan    <= (state_nxt == SCAN);
        end
    end

    // Pixel colour: RAM data in the grid, background around it, black else.
    always_comb begin
        pix_color = '0;
        if (p_vis && p_scan) pix_color = p_win ? read_data : BG_COLOR;
    end

    // Stage 2: register colour and delayed sync/blank together.
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_en) begin
            VGA_HS      <= p_hs;
            VGA_VS      <= p_vs;
            VGA_BLANK_N <= p_vis;
            VGA_R       <= {10{pix_color[2]}};
            VGA_G       <= {10{pix_color[1]}};
            VGA_B       <= {10{pix_color[0]}};
        end
    end

endmodule

// File: tb/tb_vmem_scanner.sv
// tb_vmem_scanner: scoreboard bench for vmem_scanner on a reduced raster
// (304x32 total, 288x28 visible, 34x3 grid at (8,2)).
module tb_vmem_scanner;

    localparam int S_ADDR = 0, S_R = 1, S_G = 2, S_B = 3, S_HS = 4;
    localparam int S_VS = 5, S_BLANK = 6, S_OUT = 7, S_VCLK = 8;
    localparam int S_SYNC = 9;
    localparam int ON = 1023;

    typedef struct {
        int    when;
        int    sel;
        int    exp;
        string name;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_cont = 1'b0;
    logic        next_fin = 1'b0;
    logic        out_cont;
    logic [10:0] read_addr;
    logic [2:0]  read_data = 3'b000;
    logic        vga_clk, hs, vs, blank_n, sync_n;
    logic [9:0]  r, g, b;

    logic [2:0]  mem [0:2047];
    chk_t        sb[$];
    int          rise_q[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          free_viol = 0;
    int          hs_low = 0;
    bit          free_run = 1'b1;
    bit          oc_prev = 1'b0;

    vmem_scanner #(
        .MEM_BITS(11), .COLOR_SIZE(3), .GRID_W(34), .GRID_H(3),
        .CELL_LOG2(3), .X_OFF(8), .Y_OFF(2), .BG_COLOR(3'b010),
        .H_VIS(288), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(28), .V_FP(1), .V_SYNC(1), .V_BP(2)
    ) dut (
        .Clck(clk), .Reset(rst),
        .in_cont_signal(in_cont), .out_cont_signal(out_cont),
        .next_fin_signal(next_fin),
        .read_addr(read_addr), .read_data(read_data),
        .VGA_CLK(vga_clk), .VGA_HS(hs), .VGA_VS(vs),
        .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n),
        .VGA_R(r), .VGA_G(g), .VGA_B(b)
    );

    always #10 clk = ~clk;

    always @(posedge clk) read_data <= mem[read_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    function automatic int peek(int s);
        case (s)
            S_ADDR:  return int'(read_addr);
            S_R:     return int'(r);
            S_G:     return int'(g);
            S_B:     return int'(b);
            S_HS:    return int'(hs);
            S_VS:    return int'(vs);
            S_BLANK: return int'(blank_n);
            S_OUT:   return int'(out_cont);
            S_VCLK:  return int'(vga_clk);
            S_SYNC:  return int'(sync_n);
            default: return -1;
        endcase
    endfunction

    task automatic push(int w, int s, int x, string n);
        chk_t e;
        int   i;
        e.when = w;
        e.sel  = s;
        e.exp  = x;
        e.name = n;
        i = 0;
        while (i < sb.size() && sb[i].when <= w) i++;
        sb.insert(i, e);
    endtask

    task automatic push_rgb(int w, int rv, int gv, int bv, string n);
        push(w, S_R, rv, {n, "_r"});
        push(w, S_G, gv, {n, "_g"});
        push(w, S_B, bv, {n, "_b"});
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: pops due expectations and watches the token output.
    always @(negedge clk) begin : mon
        chk_t e;
        if (free_run) begin
            if (read_addr != 0 || r != 0 || g != 0 || b != 0) free_viol++;
            if (cyc >= 608 && cyc < 1216 && !hs) hs_low++;
        end
        if (out_cont && !oc_prev) begin
            if (rise_q.size() == 0) check("out_cont_unexpected_rise", cyc, -1);
            else check("out_cont_rise_cycle", cyc, rise_q.pop_front());
        end
        oc_prev = out_cont;
        while (sb.size() > 0 && sb[0].when <= cyc) begin
            e = sb.pop_front();
            if (e.when < cyc) check({e.name, "_missed"}, cyc, e.when);
            else check(e.name, peek(e.sel), e.exp);
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 3'b000;
        mem[0]   = 3'b110;
        mem[35]  = 3'b100;
        mem[73]  = 3'b101;
        mem[101] = 3'b011;

        push(0, S_ADDR, 0, "rst_addr");
        push(0, S_OUT, 0, "rst_out_cont");
        push(0, S_HS, 1, "rst_hs");
        push(0, S_VS, 1, "rst_vs");
        push(0, S_BLANK, 0, "rst_blank");
        push(0, S_VCLK, 0, "rst_vga_clk");
        push_rgb(0, 0, 0, 0, "rst_rgb");

        push(1, S_VCLK, 1, "vga_clk_hi");
        push(2, S_VCLK, 0, "vga_clk_lo");
        push(2, S_SYNC, 0, "sync_n");
        push(577, S_BLANK, 1, "blank_h287");
        push(578, S_BLANK, 0, "blank_h288");
        push(1193, S_HS, 1, "hs_before");
        push(1194, S_HS, 0, "hs_first");
        push(1209, S_HS, 0, "hs_last");
        push(1210, S_HS, 1, "hs_after");
        push(16992, S_BLANK, 1, "blank_v27");
        push(17026, S_BLANK, 0, "blank_v28");
        push(17633, S_VS, 1, "vs_before");
        push(17634, S_VS, 0, "vs_first");
        push(18241, S_VS, 0, "vs_last");
        push(18242, S_VS, 1, "vs_after");

        push(31712, S_ADDR, 0, "arm_addr_zero");

        push(40142, S_ADDR, 0, "addr_left_edge");
        push(40144, S_ADDR, 0, "addr_cell0");
        push(40144, S_BLANK, 1, "blank_left_edge");
        push_rgb(40144, 0, ON, 0, "bg_left_edge");
        push_rgb(40146, ON, ON, 0, "cell0_color");
        push(45024, S_ADDR, 35, "addr_35");
        push_rgb(45026, ON, 0, 0, "cell35_color");
        push(49952, S_ADDR, 73, "addr_73");
        push_rgb(49954, ON, 0, ON, "cell73_color");
        push(49954, S_BLANK, 1, "blank_73");
        push(50434, S_BLANK, 0, "blank_h_ge_vis");
        push(50434, S_G, 0, "rgb_h_ge_vis_g");
        push(54670, S_ADDR, 101, "addr_last_cell");
        push(54672, S_ADDR, 0, "addr_right_edge");
        push_rgb(54672, 0, ON, ON, "last_cell_color");
        push_rgb(54674, 0, ON, 0, "bg_right_edge");
        push(55278, S_ADDR, 0, "addr_below_grid");
        push(55935, S_OUT, 0, "out_cont_pre");
        rise_q.push_back(55936);
        push(56036, S_OUT, 1, "out_cont_held");
        push(56037, S_OUT, 0, "out_cont_fall");

        push(69408, S_ADDR, 73, "rearm_addr_73");
        push_rgb(69410, ON, 0, ON, "rearm_color");
        push(70728, S_ADDR, 79, "addr_79_pre_rst");

        repeat (3) @(negedge clk);
        rst = 1'b0;

        wait_cyc(25636);
        free_run = 1'b0;
        check("free_run_addr_rgb_zero", free_viol, 0);
        check("hs_low_cycles_line", hs_low, 16);
        in_cont = 1'b1;
        wait_cyc(25646);
        in_cont = 1'b0;

        wait_cyc(56036);
        next_fin = 1'b1;
        in_cont  = 1'b1;
        wait_cyc(56037);
        next_fin = 1'b0;
        wait_cyc(56100);
        in_cont = 1'b0;

        wait_cyc(70728);
        #3 rst = 1'b1;
        #1;
        check("async_rst_addr", int'(read_addr), 0);
        check("async_rst_out", int'(out_cont), 0);
        check("async_rst_blank", int'(blank_n), 0);
        check("async_rst_hs", int'(hs), 1);
        check("async_rst_vclk", int'(vga_clk), 0);
        check("queue_empty_at_rst", sb.size(), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        push(1248, S_ADDR, 0, "post_rst_idle_addr");
        push(1249, S_OUT, 0, "post_rst_out_cont");
        wait_cyc(1300);
        check("scoreboard_drained", sb.size(), 0);
        check("rise_queue_drained", rise_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vmem_scanner.md
# vmem_scanner

Read-side counterpart of the painter's video-memory write port. It owns the VGA raster and, once per continuation token, scans one full frame of the 34×33-cell colour RAM out to the DAC. It then reports completion on the continuation chain. It drives the RAM read address onto the shared OR'ed address bus and must hold that address at zero whenever it is not scanning.

## Interface
- MEM_BITS, 11: RAM address width.
- COLOR_SIZE, 3: colour word width, ordered {R,G,B}.
- GRID_W, 34: cells per row.
- GRID_H, 33: cell rows.
- CELL_LOG2, 3: cell edge of 8 pixels.
- X_OFF, 184: first grid pixel column.
- Y_OFF, 108: first grid pixel row.
- BG_COLOR, 3'b000: colour for visible pixels outside the grid.

Ports:
- Clck, in, 1: system clock (50 MHz).
- Reset, in, 1: asynchronous, active-high.
- in_cont_signal, in, 1: start token from the preceding continuation.
- out_cont_signal, out, 1: frame-scanned token to the next continuation.
- next_fin_signal, in, 1: next continuation has taken the token.
- read_addr, out, MEM_BITS: RAM read address; 0 when not scanning.
- read_data, in, COLOR_SIZE: RAM q, valid one Clck after the address.
- VGA_CLK, out, 1: Clck/2.
- VGA_HS, out, 1: horizontal sync, active-low.
- VGA_VS, out, 1: vertical sync, active-low.
- VGA_BLANK_N, out, 1: high in the visible region.
- VGA_SYNC_N, out, 1: constant 0.
- VGA_R, out, 10: red.
- VGA_G, out, 10: green.
- VGA_B, out, 10: blue.

## Operation
- **Pixel tick:** a toggle flop produces `pix_en` every 2nd Clck. VGA_CLK is that toggle.
- **Raster:** hcount runs 0..799 and vcount 0..524. Both advance only on `pix_en` and run freely in every state.
  - Visible region: h<640 and v<480.
  - HS low for h in 656..751.
  - VS low for v in 490..491.
- **Cell mapping:** inside the window X_OFF ≤ h < X_OFF+GRID_W·8 and Y_OFF ≤ v < Y_OFF+GRID_H·8:
  - cx = (h−X_OFF)>>3, cy = (v−Y_OFF)>>3
  - addr = cy·GRID_W + cx, in the range 0..1121
  - cy·34 is computed as (cy<<5)+(cy<<1), with no multiplier.
- **State machine:**
  - IDLE: read_addr=0, RGB=0. If in_cont_signal=1, go to ARM.
  - ARM: read_addr=0. On the `pix_en` edge where the counters wrap to (0,0), go to SCAN.
  - SCAN: read_addr = addr inside the window, otherwise 0. Visible pixels show read_data inside the window and BG_COLOR outside. On the `pix_en` edge where vcount becomes 480, go to DONE and set out_cont_signal=1.
  - DONE: read_addr=0 and out_cont_signal held at 1. When next_fin_signal=1, clear out_cont_signal on that edge and go to IDLE.
- in_cont_signal is ignored in ARM, SCAN and DONE.
- If in_cont_signal is still high on the edge after DONE→IDLE, the block re-arms (IDLE→ARM on the next edge).
- **Colour expansion:** each colour bit expands to 10'h3FF or 10'h000 (R=bit2, G=bit1, B=bit0). RGB is 0 whenever BLANK_N=0.
- **Reset:** asynchronous, and allowed mid-frame. It forces:
  - IDLE state, counters 0, toggle 0, VGA_CLK=0
  - read_addr=0, out_cont_signal=0
  - HS=1, VS=1, BLANK_N=0, RGB=0
- No RAM write path exists in this block.

## Timing
- **Pipeline**, three stages of one Clck each:
  - Edge k (`pix_en`): counters update and read_addr is registered.
  - Edge k+1: RAM q becomes valid.
  - Edge k+2 (next `pix_en`): VGA_R/G/B, HS, VS and BLANK_N are registered together.
- HS, VS and BLANK_N pass through a one-pixel delay register so they stay aligned with the colour data. Net output latency is one pixel (2 Clck).
- Periods: line = 1600 Clck; frame = 840,000 Clck.
- Once the counters are at (0,0) with in_cont_signal high in ARM, out_cont_signal rises 480·1600 = 768,000 Clck later.
- out_cont_signal is registered. It falls on the edge that samples next_fin_signal=1.

## Test plan
- **Reset and free run:** Reset pulse, in_cont_signal=0 → all outputs take their reset values. HS low for 192 Clck every 1600. read_addr stays 0 and RGB stays 0 for 2 frames.
- **Addressing:** preload RAM[73]=3'b101, then token → at pixel (X_OFF+40, Y_OFF+16), read_addr=73. One pixel later R=3FF, G=0, B=3FF, BLANK_N=1.
- **Handshake:** token raised mid-frame → state waits in ARM until (0,0). out_cont_signal rises 768,000 Clck later and holds 100 cycles until next_fin_signal=1, then falls on that edge.
- **Window boundaries:** h=X_OFF−1 shows BG_COLOR with read_addr=0. The last cell (v=Y_OFF+263, h=X_OFF+271) gives read_addr=1121. h≥640 gives BLANK_N=0 and RGB=0.
- **Simultaneous events:** in_cont_signal held high while next_fin_signal pulses in DONE → the block returns to IDLE, re-arms on the next edge, and scans the following frame.
- **Reset mid-SCAN:** at v=200 → out_cont_signal stays 0. The block returns to IDLE immediately and read_addr=0.
